alu_sequencer: RTL

//  Request/response front end that sequences the shared 8-bit ALU for one arithmetic/logic op per transaction.

---
 rtl/alu_seq_pkg.sv | 134 +++++++++++++
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, FSM states, ALU latch/output selects, flag indices,
// plus the opcode-to-control decode and flag derivation helpers.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBC  = 4'd3,
    OP_AND  = 4'd4,
    OP_XOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_CP   = 4'd7,
    OP_SWAP = 4'd8,
    OP_INC  = 4'd9,
    OP_DEC  = 4'd10
  } alu_seq_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LDA,
    ST_LDB,
    ST_EXEC,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    NO_LD   = 2'd0,
    ZERO_LD = 2'd1,
    BUS_LD  = 2'd2
  } ld_sel_t;

  typedef enum logic [1:0] {
    RES_OE = 2'd0,
    SH_OE  = 2'd1
  } oe_sel_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic    legal;
    logic    ne;
    logic    ci;
    oe_sel_t oe;
    ld_sel_t la;
    ld_sel_t lb;
    logic    imm_one;
    logic    swap_bus;
  } alu_ctrl_t;

  function automatic alu_ctrl_t decode_op(input logic [3:0] op, input logic cin);
    alu_ctrl_t c;
    c.legal    = 1'b1;
    c.ne       = 1'b0;
    c.ci       = 1'b0;
    c.oe       = RES_OE;
    c.la       = BUS_LD;
    c.lb       = BUS_LD;
    c.imm_one  = 1'b0;
    c.swap_bus = 1'b0;
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_OR: ;
      OP_ADC: c.ci = cin;
      OP_SUB, OP_CP: begin
        c.ne = 1'b1;
        c.ci = 1'b1;
      end
      OP_SBC: begin
        c.ne = 1'b1;
        c.ci = ~cin;
      end
      // SWAP clears A and routes the operand through B into the nibble shifter.
      OP_SWAP: begin
        c.oe       = SH_OE;
        c.la       = ZERO_LD;
        c.swap_bus = 1'b1;
      end
      OP_INC: c.imm_one = 1'b1;
      OP_DEC: begin
        c.imm_one = 1'b1;
        c.ne      = 1'b1;
        c.ci      = 1'b1;
      end
      default: begin
        c.legal = 1'b0;
        c.la    = NO_LD;
        c.lb    = NO_LD;
      end
    endcase
    return c;
  endfunction

  function automatic logic [3:0] calc_flags(input logic [3:0] op, input logic cin,
                                            input logic zero, input logic carry, input logic half);
    logic [3:0] f;
    f = 4'b0000;
    case (op)
      OP_ADD, OP_ADC: begin
        f[FLAG_Z] = zero;
        f[FLAG_H] = half;
        f[FLAG_C] = carry;
      end
      // Subtraction is done as A + ~B + ci, so borrow and half-borrow are the inverted carries.
      OP_SUB, OP_SBC, OP_CP: begin
        f[FLAG_Z] = zero;
        f[FLAG_N] = 1'b1;
        f[FLAG_H] = ~half;
        f[FLAG_C] = ~carry;
      end
      OP_AND: begin
        f[FLAG_Z] = zero;
        f[FLAG_H] = 1'b1;
      end
      OP_XOR, OP_OR, OP_SWAP: f[FLAG_Z] = zero;
      OP_INC: begin
        f[FLAG_Z] = zero;
        f[FLAG_H] = half;
        f[FLAG_C] = cin;
      end
      OP_DEC: begin
        f[FLAG_Z] = zero;
        f[FLAG_N] = 1'b1;
        f[FLAG_H] = ~half;
        f[FLAG_C] = cin;
      end
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Request/response front end sequencing the shared 8-bit ALU over a fixed LDA/LDB/EXEC schedule.
// Optional ALU_SEQ_OVERLAP_EN: accept the next request during the response handshake cycle.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_cin,
  output logic [7:0] alu_bus,
  output logic [1:0] alu_la,
  output logic [1:0] alu_lb,
  output logic [1:0] alu_oe,
  output logic       alu_ne,
  output logic       alu_ci,
  output logic       alu_l,
  output logic       alu_h,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  input  logic       alu_half,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic       rsp_illegal
);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic [3:0] rsp_flags_q, rsp_flags_d;
  logic       rsp_illegal_q, rsp_illegal_d;

  alu_ctrl_t  ctrl;
  logic       req_fire;
  logic       rsp_fire;

  assign ctrl = decode_op(op_q, cin_q);

`ifdef ALU_SEQ_OVERLAP_EN
  assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  assign req_fire = req_valid & req_ready;
  assign rsp_fire = rsp_valid_q & rsp_ready;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    cin_d         = cin_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;

    if (req_fire) begin
      op_d  = req_op;
      a_d   = req_a;
      b_d   = req_b;
      cin_d = req_cin;
    end

    case (state_q)
      ST_IDLE: if (req_fire) state_d = ST_LDA;
      ST_LDA:  state_d = ST_LDB;
      ST_LDB:  state_d = ST_EXEC;
      ST_EXEC: begin
        state_d       = ST_RESP;
        rsp_valid_d   = 1'b1;
        rsp_result_d  = ctrl.legal ? ((op_q == OP_CP) ? a_q : alu_result) : 8'h00;
        rsp_flags_d   = calc_flags(op_q, cin_q, alu_zero, alu_carry, alu_half);
        rsp_illegal_d = ~ctrl.legal;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          state_d     = req_fire ? ST_LDA : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_bus = 8'h00;
    alu_la  = NO_LD;
    alu_lb  = NO_LD;
    alu_oe  = RES_OE;
    alu_ne  = 1'b0;
    alu_ci  = 1'b0;
    alu_l   = 1'b0;
    alu_h   = 1'b0;
    if (ctrl.legal) begin
      case (state_q)
        ST_LDA: begin
          alu_bus = a_q;
          alu_la  = ctrl.la;
        end
        ST_LDB: begin
          alu_bus = ctrl.imm_one ? 8'h01 : (ctrl.swap_bus ? a_q : b_q);
          alu_lb  = ctrl.lb;
        end
        ST_EXEC: begin
          alu_l  = 1'b1;
          alu_h  = 1'b1;
          alu_oe = ctrl.oe;
          alu_ne = ctrl.ne;
          alu_ci = ctrl.ci;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 8'h00;
      rsp_flags_q   <= 4'h0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // Captured operands are qualified by the FSM, so they need no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    cin_q <= cin_d;
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;

endmodule
